// File: rtl/sipo_bar_mc.sv
// Serial-in/parallel-out word assembler with a one-word skid held in the fill buffer.
// Optional synchronous discard input enabled by defining SIPO_BAR_MC_FLUSH_EN.
module sipo_bar_mc #(
  parameter int IN_WIDTH  = 64,
  parameter int NUM_MAX   = 3,
  parameter int OUT_WIDTH = IN_WIDTH * NUM_MAX,
  parameter int CNT_W     = $clog2(NUM_MAX + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [CNT_W-1:0]     cfg_num,
  input  logic                 in_valid,
  input  logic [IN_WIDTH-1:0]  in_data,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [OUT_WIDTH-1:0] out_data,
  input  logic                 out_ready,
`ifdef SIPO_BAR_MC_FLUSH_EN
  input  logic                 flush,
`endif
  output logic                 busy
);

  localparam logic [CNT_W-1:0] NUM_MAX_C = CNT_W'(NUM_MAX);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_FULL = 2'd2
  } state_t;

  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [CNT_W-1:0]     r_num;
  logic [OUT_WIDTH-1:0] r_fill;
  logic                 r_out_valid;
  logic [OUT_WIDTH-1:0] r_out_data;

  logic                 w_beat;
  logic                 w_word;
  logic                 w_slot_free;
  logic [CNT_W-1:0]     w_n_eff;
  logic [CNT_W-1:0]     w_num;
  logic [CNT_W:0]       w_cnt_inc;
  logic                 w_last;
  logic [OUT_WIDTH-1:0] w_shift;

  assign in_ready  = (r_state != S_FULL);
  assign busy      = (r_state != S_IDLE);
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

  assign w_beat      = in_valid && in_ready;
  assign w_word      = r_out_valid && out_ready;
  assign w_slot_free = !r_out_valid || out_ready;

  // Out-of-range or zero beat counts fall back to the full word size.
  assign w_n_eff   = ((cfg_num == '0) || (cfg_num > NUM_MAX_C)) ? NUM_MAX_C : cfg_num;
  assign w_num     = (r_cnt == '0) ? w_n_eff : r_num;
  assign w_cnt_inc = {1'b0, r_cnt} + {{CNT_W{1'b0}}, 1'b1};
  assign w_last    = (w_cnt_inc == {1'b0, w_num});

  // The fill buffer is zero at word start, so unused upper slots stay zero.
  assign w_shift = (r_fill << IN_WIDTH) | OUT_WIDTH'(in_data);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_num       <= NUM_MAX_C;
      r_fill      <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
`ifdef SIPO_BAR_MC_FLUSH_EN
      if (flush) begin
        r_state     <= S_IDLE;
        r_cnt       <= '0;
        r_fill      <= '0;
        r_out_valid <= 1'b0;
      end else
`endif
      begin
        // A load later in this block overrides the clear on a same-cycle accept.
        if (w_word) r_out_valid <= 1'b0;

        case (r_state)
          S_IDLE, S_FILL: begin
            if (w_beat) begin
              if (r_cnt == '0) r_num <= w_n_eff;
              if (w_last) begin
                r_cnt <= '0;
                if (w_slot_free) begin
                  r_out_data  <= w_shift;
                  r_out_valid <= 1'b1;
                  r_fill      <= '0;
                  r_state     <= S_IDLE;
                end else begin
                  r_fill  <= w_shift;
                  r_state <= S_FULL;
                end
              end else begin
                r_cnt   <= w_cnt_inc[CNT_W-1:0];
                r_fill  <= w_shift;
                r_state <= S_FILL;
              end
            end
          end
          S_FULL: begin
            if (w_slot_free) begin
              r_out_data  <= r_fill;
              r_out_valid <= 1'b1;
              r_fill      <= '0;
              r_state     <= S_IDLE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sipo_bar_mc.sv
// Directed, table-driven bench for sipo_bar_mc with IN_WIDTH=8, NUM_MAX=4.
module tb_sipo_bar_mc;

  localparam int IW = 8;
  localparam int NM = 4;
  localparam int OW = IW * NM;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [CW-1:0] cfg_num;
  logic          in_valid;
  logic [IW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic [OW-1:0] out_data;
  logic          out_ready;
  logic          busy;
`ifdef SIPO_BAR_MC_FLUSH_EN
  logic          flush = 1'b0;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  sipo_bar_mc #(.IN_WIDTH(IW), .NUM_MAX(NM), .OUT_WIDTH(OW), .CNT_W(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .cfg_num   (cfg_num),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
`ifdef SIPO_BAR_MC_FLUSH_EN
    .flush     (flush),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CW-1:0] cfg;
    logic          vld;
    logic [IW-1:0] dat;
    logic          rdy;
    logic          e_ov;
    logic [OW-1:0] e_od;
    logic          e_ir;
    logic          e_busy;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic ov, input logic [OW-1:0] od,
                         input logic ir, input logic bz);
    chk({tag, " out_valid"}, OW'(out_valid), OW'(ov));
    chk({tag, " out_data"},  out_data, od);
    chk({tag, " in_ready"},  OW'(in_ready), OW'(ir));
    chk({tag, " busy"},      OW'(busy), OW'(bz));
  endtask

  task automatic drive(input logic [CW-1:0] c, input logic v, input logic [IW-1:0] d, input logic r);
    cfg_num   = c;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [CW-1:0] c, input logic v, input logic [IW-1:0] d, input logic r,
                     input logic ov, input logic [OW-1:0] od, input logic ir, input logic bz);
    vec_t t;
    t.cfg = c; t.vld = v; t.dat = d; t.rdy = r;
    t.e_ov = ov; t.e_od = od; t.e_ir = ir; t.e_busy = bz;
    vecs.push_back(t);
  endtask

  initial begin
    reset = 1'b0; cfg_num = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    // Four-beat word with free output.
    add(4, 1, 8'h11, 1, 0, 32'h0, 1, 1);
    add(4, 1, 8'h22, 1, 0, 32'h0, 1, 1);
    add(4, 1, 8'h33, 1, 0, 32'h0, 1, 1);
    add(4, 1, 8'h44, 1, 1, 32'h11223344, 1, 0);
    add(4, 0, 8'h00, 1, 0, 32'h11223344, 1, 0);
    // Two-beat word, then cfg_num=0 selects four beats.
    add(2, 1, 8'hAA, 1, 0, 32'h11223344, 1, 1);
    add(2, 1, 8'hBB, 1, 1, 32'h0000AABB, 1, 0);
    add(0, 1, 8'h01, 1, 0, 32'h0000AABB, 1, 1);
    add(0, 1, 8'h02, 1, 0, 32'h0000AABB, 1, 1);
    add(0, 1, 8'h03, 1, 0, 32'h0000AABB, 1, 1);
    add(0, 1, 8'h04, 1, 1, 32'h01020304, 1, 0);
    add(0, 0, 8'h00, 1, 0, 32'h01020304, 1, 0);
    // Output stalled across eight beats: second word parks in the fill buffer.
    add(4, 1, 8'h01, 0, 0, 32'h01020304, 1, 1);
    add(4, 1, 8'h02, 0, 0, 32'h01020304, 1, 1);
    add(4, 1, 8'h03, 0, 0, 32'h01020304, 1, 1);
    add(4, 1, 8'h04, 0, 1, 32'h01020304, 1, 0);
    add(4, 1, 8'h05, 0, 1, 32'h01020304, 1, 1);
    add(4, 1, 8'h06, 0, 1, 32'h01020304, 1, 1);
    add(4, 1, 8'h07, 0, 1, 32'h01020304, 1, 1);
    add(4, 1, 8'h08, 0, 1, 32'h01020304, 0, 1);
    add(4, 1, 8'h77, 0, 1, 32'h01020304, 0, 1);
    add(4, 1, 8'h99, 1, 1, 32'h05060708, 1, 0);
    add(4, 0, 8'h00, 1, 0, 32'h05060708, 1, 0);
    // Continuous 3-beat words; cfg_num change mid-word is ignored.
    add(3, 1, 8'h01, 1, 0, 32'h05060708, 1, 1);
    add(1, 1, 8'h02, 1, 0, 32'h05060708, 1, 1);
    add(1, 1, 8'h03, 1, 1, 32'h00010203, 1, 0);
    add(3, 1, 8'h04, 1, 0, 32'h00010203, 1, 1);
    add(3, 1, 8'h05, 1, 0, 32'h00010203, 1, 1);
    add(3, 1, 8'h06, 1, 1, 32'h00040506, 1, 0);
    add(3, 1, 8'h07, 1, 0, 32'h00040506, 1, 1);
    add(3, 1, 8'h08, 1, 0, 32'h00040506, 1, 1);
    add(3, 1, 8'h09, 1, 1, 32'h00070809, 1, 0);
    add(3, 1, 8'h0A, 1, 0, 32'h00070809, 1, 1);
    add(3, 1, 8'h0B, 1, 0, 32'h00070809, 1, 1);
    add(3, 1, 8'h0C, 1, 1, 32'h000A0B0C, 1, 0);
    // One-beat words go straight through, back-to-back.
    add(1, 1, 8'hE1, 1, 1, 32'h000000E1, 1, 0);
    add(1, 1, 8'hE2, 1, 1, 32'h000000E2, 1, 0);
    // Over-range cfg_num behaves as NUM_MAX.
    add(7, 1, 8'hC1, 0, 1, 32'h000000E2, 1, 1);
    add(7, 1, 8'hC2, 0, 1, 32'h000000E2, 1, 1);
    add(7, 1, 8'hC3, 0, 1, 32'h000000E2, 1, 1);
    add(7, 1, 8'hC4, 1, 1, 32'hC1C2C3C4, 1, 0);

    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 0, 32'h0, 1, 0);
    reset = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].cfg, vecs[i].vld, vecs[i].dat, vecs[i].rdy);
      chk_all($sformatf("v%0d", i), vecs[i].e_ov, vecs[i].e_od, vecs[i].e_ir, vecs[i].e_busy);
    end

    // Asynchronous reset mid-word clears everything, including the held word.
    drive(4, 1, 8'hF1, 0);
    drive(4, 1, 8'hF2, 0);
    chk_all("pre_rst", 1, 32'hC1C2C3C4, 1, 1);
    #2 reset = 1'b0;
    #1;
    chk_all("mid_rst", 0, 32'h0, 1, 0);
    #1 reset = 1'b1;
    drive(4, 1, 8'h05, 1);
    drive(4, 1, 8'h06, 1);
    drive(4, 1, 8'h07, 1);
    chk_all("post_rst3", 0, 32'h0, 1, 1);
    drive(4, 1, 8'h08, 1);
    chk_all("post_rst4", 1, 32'h05060708, 1, 0);
    drive(4, 0, 8'h00, 1);

`ifdef SIPO_BAR_MC_FLUSH_EN
    // Flush after three beats drops the concurrent beat and the partial word.
    drive(4, 1, 8'hD1, 1);
    drive(4, 1, 8'hD2, 1);
    drive(4, 1, 8'hD3, 1);
    flush = 1'b1;
    drive(4, 1, 8'hD4, 1);
    flush = 1'b0;
    chk_all("flush", 0, 32'h05060708, 1, 0);
    drive(4, 1, 8'h21, 1);
    drive(4, 1, 8'h22, 1);
    drive(4, 1, 8'h23, 1);
    drive(4, 1, 8'h24, 1);
    chk_all("post_flush", 1, 32'h21222324, 1, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sipo_bar_mc.md
# sipo_bar_mc

Parametrised, handshaked serial-in/parallel-out assembler for activations and weights. It packs a run-time-selectable number of IN_WIDTH beats into one OUT_WIDTH word and holds that word in an output register until the consumer accepts it. A skid stage lets the next word fill while the current one waits. It sits between the memory-controller read path and the PE-array row loaders.

## Interface
Parameters:
- IN_WIDTH, default 64: width of one serial beat.
- NUM_MAX, default 3: maximum beats per word.
- OUT_WIDTH, default IN_WIDTH*NUM_MAX: parallel word width. Must equal IN_WIDTH*NUM_MAX.
- CNT_W, default `C_LOG_2(NUM_MAX+1)`: width of the beat counter and of cfg_num.

Ports:
- clk, input, 1: clock.
- reset, input, 1: asynchronous, active-low.
- cfg_num, input, CNT_W: beats per word. Sampled on the first accepted beat of each word.
- in_valid, input, 1: serial beat valid.
- in_data, input, IN_WIDTH: serial beat.
- in_ready, output, 1: block can accept a beat.
- out_valid, output, 1: parallel word valid.
- out_data, output, OUT_WIDTH: parallel word.
- out_ready, input, 1: consumer accepts the word.
- busy, output, 1: a partial or full word is held in the fill buffer.
- flush, input, 1: synchronous discard. Present only with SIPO_BAR_MC_FLUSH_EN.

## Operation
- Beat accepted: in_valid && in_ready.
- Word accepted: out_valid && out_ready.
- Effective beat count: n_eff = NUM_MAX if cfg_num==0 or cfg_num>NUM_MAX, otherwise cfg_num. It is latched into num_q when cnt==0 and a beat is accepted, so cfg_num changes mid-word are ignored.
- Fill buffer fill_q shifts left by IN_WIDTH per accepted beat, inserting in_data at the LSBs.
- Completed word layout: beat 0 in the highest used slot, the last beat at [IN_WIDTH-1:0]. Slots above n_eff*IN_WIDTH are zero.
- States:
  - IDLE: cnt==0.
  - FILL: 0<cnt<num_q.
  - FULL: complete word held, output slot occupied.
- Transitions:
  - IDLE→FILL on an accepted beat when n_eff>1.
  - FILL→FILL while beats are accepted and cnt+1<num_q.
  - Final beat accepted (from IDLE or FILL):
    - If the output slot is free (!out_valid || out_ready in the same cycle): load out_data <= {fill_q<<IN_WIDTH | in_data}, zero-padded; set out_valid; go to IDLE.
    - Otherwise: store the completed word in fill_q and go to FULL.
  - FULL→IDLE when !out_valid || out_ready: transfer fill_q to out_data and keep out_valid=1.
- Combinational outputs:
  - in_ready = (state != FULL).
  - busy = (state != IDLE).
- out_valid clears on a word acceptance with no simultaneous load.
- out_data holds its value after acceptance; it is only rewritten on a load.

## Timing
- Reset values: out_valid=0, out_data=0, in_ready=1, busy=0, cnt=0, num_q=NUM_MAX, fill_q=0.
- Latency: out_valid rises on the clock edge that accepts the final beat, i.e. it is visible in the next cycle.
- Throughput: one word per n_eff cycles with in_valid=1 and out_ready=1, with no bubbles.
- Back-to-back: final-beat load and word accept in the same cycle leave out_valid=1 with the new data.
- Output stall: at most one complete word waits in fill_q, and in_ready drops the cycle after FULL is entered.
- A FULL→IDLE transfer and a new beat cannot coincide, because in_ready=0 in FULL.
- Reset asserted mid-word discards all data immediately, including fill_q and out_data.
- n_eff=1: every beat goes straight to the output, and state FILL is never entered.

## Configuration
- SIPO_BAR_MC_FLUSH_EN defined:
  - flush port exists.
  - When flush=1 at a clock edge: cnt<=0, fill_q<=0, out_valid<=0, state goes to IDLE.
  - flush takes priority over beat and word acceptance in the same cycle.
  - out_data is not cleared.
- SIPO_BAR_MC_FLUSH_EN undefined: no flush port. Partial words are discarded only by reset.

## Test plan
- IN_WIDTH=8, NUM_MAX=4, cfg_num=4, beats 0x11,0x22,0x33,0x44, out_ready=1 → one cycle after the 4th beat, out_valid=1 and out_data=0x11223344.
- cfg_num=2, beats 0xAA,0xBB → out_data=0x0000AABB. Then cfg_num=0 with 4 beats 0x01..0x04 → out_data=0x01020304.
- out_ready=0 and 8 consecutive beats 1..8 → first word 0x01020304 appears; after beat 8, in_ready=0 and busy=1. Raise out_ready for one cycle → out_data=0x05060708, in_ready=1 again.
- Continuous 12 beats with out_ready=1 and cfg_num=3 → four words on cycles 3,6,9,12, no in_ready deassertion. Change cfg_num to 1 after beat 1 → word 0 is still 3 beats.
- Assert reset after 2 of 4 beats → all outputs at reset values. Next 4 beats 0x5,0x6,0x7,0x8 → out_data=0x05060708.
- With SIPO_BAR_MC_FLUSH_EN: flush after 3 beats, concurrent with in_valid=1 → beat dropped, cnt=0. Next word is assembled from fresh beats only.
